pulse_stretcher: RTL and testbench

Inverse of the one-pulser. Converts single-cycle request pulses into fixed-width long pulses of HIGH_CYCLES clocks, separated by a GAP_CYCLES low interval. Requests that arrive while a stretched pulse or gap is in progress are counted and replayed in order, so no request is lost until the pending counter saturates. Drives LEDs or slow downstream logic from one-pulser outputs or from internal event strobes.

---
 rtl/pulse_stretcher.sv | 150 +++++++++++++++
 tb/tb_pulse_stretcher.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle request strobes into
// HIGH_CYCLES-wide pulses separated by GAP_CYCLES low cycles.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   singlePulse  request strobe (one request per sampled-high cycle)
//   clrOverflow  clears the sticky overflow flag
//   longPulse    registered stretched pulse
//   busy         high while not IDLE
//   pendingCount requests queued but not yet started
//   overflow     sticky, set when a request is dropped
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 20,
  parameter int GAP_CYCLES  = 4,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              singlePulse,
  input  logic              clrOverflow,
  output logic              longPulse,
  output logic              busy,
  output logic [PEND_W-1:0] pendingCount,
  output logic              overflow
);

  localparam int CMAX_HG =
    (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CMAX  = (CMAX_HG > 2) ? CMAX_HG : 2;
  localparam int CNT_W = $clog2(CMAX);

  localparam logic [CNT_W-1:0] HIGH_LD =
    CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD =
    CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [PEND_W-1:0] PMAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              lp_q, lp_d;
  logic              busy_q, busy_d;

  logic              active;
  logic              accept;
  logic              drop;
  logic              period_end;
  logic [PEND_W-1:0] pend_inc;

  // Requests while a pulse/gap runs are queued, or dropped
  // once the queue is full.
  assign active   = (state_q != IDLE);
  assign accept   = singlePulse & active & (pend_q != PMAX);
  assign drop     = singlePulse & active & (pend_q == PMAX);
  assign pend_inc = pend_q + PEND_W'(accept);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    period_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (singlePulse) begin
          state_d = HIGH;
          cnt_d   = HIGH_LD;
        end
      end
      HIGH: begin
        pend_d = pend_inc;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (HAS_GAP) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          period_end = 1'b1;
        end
      end
      GAP: begin
        pend_d = pend_inc;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          period_end = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // A request landing on the final cycle counts as queued,
    // so it can start the next pulse straight away.
    if (period_end) begin
      if (pend_inc != '0) begin
        state_d = HIGH;
        cnt_d   = HIGH_LD;
        pend_d  = pend_inc - PEND_W'(1);
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clrOverflow) begin
      ovf_d = 1'b0;
    end
  end

  assign lp_d   = (state_d == HIGH);
  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      lp_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      lp_q    <= lp_d;
      busy_q  <= busy_d;
    end
  end

  assign longPulse    = lp_q;
  assign busy         = busy_q;
  assign pendingCount = pend_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: scoreboard bench for pulse_stretcher,
// default config (u0) and HIGH=1/GAP=0 config (u1).
module tb_pulse_stretcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, singlePulse0 = 1'b0;
  logic       clrOverflow0 = 1'b0;
  logic       longPulse0, busy0, overflow0;
  logic [2:0] pendingCount0;

  logic       rst1 = 1'b1, singlePulse1 = 1'b0;
  logic       clrOverflow1 = 1'b0;
  logic       longPulse1, busy1, overflow1;
  logic [2:0] pendingCount1;

  pulse_stretcher #(
    .HIGH_CYCLES(20), .GAP_CYCLES(4), .PEND_W(3)
  ) u0 (
    .clk(clk), .rst(rst0),
    .singlePulse(singlePulse0),
    .clrOverflow(clrOverflow0),
    .longPulse(longPulse0), .busy(busy0),
    .pendingCount(pendingCount0),
    .overflow(overflow0)
  );

  pulse_stretcher #(
    .HIGH_CYCLES(1), .GAP_CYCLES(0), .PEND_W(3)
  ) u1 (
    .clk(clk), .rst(rst1),
    .singlePulse(singlePulse1),
    .clrOverflow(clrOverflow1),
    .longPulse(longPulse1), .busy(busy1),
    .pendingCount(pendingCount1),
    .overflow(overflow1)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [5:0] v0;
    logic [5:0] v1;
  } exp_t;
  exp_t sb[$];
  exp_t ce;

  logic [5:0] dut0, dut1;
  assign dut0 = {longPulse0, busy0, pendingCount0, overflow0};
  assign dut1 = {longPulse1, busy1, pendingCount1, overflow1};

  // Reference model: phase 0 idle, 1 high, 2 gap;
  // rem = cycles left in phase including the current one.
  localparam int MAXP = 7;
  int HC[2] = '{20, 1};
  int GC[2] = '{4, 0};
  int ph[2] = '{0, 0};
  int rem[2] = '{0, 0};
  int pend[2] = '{0, 0};
  bit ovf[2] = '{1'b0, 1'b0};

  task automatic mstep(input int d, input bit rq,
                       input bit clr, input bit r);
    bit acc;
    bit drp;
    int p;
    acc = 1'b0;
    drp = 1'b0;
    if (r) begin
      ph[d] = 0; rem[d] = 0; pend[d] = 0; ovf[d] = 1'b0;
      return;
    end
    if (ph[d] == 0) begin
      if (rq) begin
        ph[d] = 1;
        rem[d] = HC[d];
      end
    end else begin
      acc = rq && (pend[d] < MAXP);
      drp = rq && !acc;
      if (rem[d] > 1) begin
        rem[d]--;
        pend[d] += int'(acc);
      end else if (ph[d] == 1 && GC[d] > 0) begin
        ph[d] = 2;
        rem[d] = GC[d];
        pend[d] += int'(acc);
      end else begin
        p = pend[d] + int'(acc);
        if (p > 0) begin
          ph[d] = 1;
          rem[d] = HC[d];
          pend[d] = p - 1;
        end else begin
          ph[d] = 0;
        end
      end
    end
    if (drp) ovf[d] = 1'b1;
    else if (clr) ovf[d] = 1'b0;
  endtask

  function automatic logic [5:0] mout(input int d);
    logic [2:0] pc;
    pc = pend[d][2:0];
    return {ph[d] == 1, ph[d] != 0, pc, ovf[d]};
  endfunction

  task automatic tick(input bit rq, input bit clr,
                      input bit r, input bit rq1,
                      input bit r1);
    exp_t e;
    @(negedge clk);
    singlePulse0 = rq;
    clrOverflow0 = clr;
    rst0 = r;
    singlePulse1 = rq1;
    clrOverflow1 = 1'b0;
    rst1 = r1;
    mstep(0, rq, clr, r);
    mstep(1, rq1, 1'b0, r1);
    e.v0 = mout(0);
    e.v1 = mout(1);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      ce = sb.pop_front();
      checks++;
      if (dut0 !== ce.v0) begin
        failures++;
        $display("FAIL sb_u0 t=%0t got=%b exp=%b",
                 $time, dut0, ce.v0);
      end
      checks++;
      if (dut1 !== ce.v1) begin
        failures++;
        $display("FAIL sb_u1 t=%0t got=%b exp=%b",
                 $time, dut1, ce.v1);
      end
    end
  end

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (dut0 !== 6'b0) begin
      failures++;
      $display("FAIL reset_u0 got=%b exp=%b", dut0, 6'b0);
    end
    checks++;
    if (dut1 !== 6'b0) begin
      failures++;
      $display("FAIL reset_u1 got=%b exp=%b", dut1, 6'b0);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    int highs;
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      tick(i == 0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (longPulse0 === 1'b1) highs++;
      if (i == 23) begin
        checks++;
        if (busy0 !== 1'b1) begin
          failures++;
          $display("FAIL single_busy23 got=%b exp=1", busy0);
        end
      end
      if (i == 24) begin
        checks++;
        if (busy0 !== 1'b0) begin
          failures++;
          $display("FAIL single_busy24 got=%b exp=0", busy0);
        end
      end
    end
    checks++;
    if (highs != 20) begin
      failures++;
      $display("FAIL single_width got=%0d exp=20", highs);
    end
  endtask

  task automatic test_queued();
    int starts;
    logic prev;
    starts = 0;
    prev = longPulse0;
    for (int i = 0; i < 80; i++) begin
      tick(i == 0 || i == 5 || i == 30,
           1'b0, 1'b0, 1'b0, 1'b0);
      if (longPulse0 === 1'b1 && prev !== 1'b1) starts++;
      prev = longPulse0;
      if (i == 5) begin
        checks++;
        if (pendingCount0 !== 3'd1) begin
          failures++;
          $display("FAIL queued_pend5 got=%0d exp=1",
                   pendingCount0);
        end
      end
      if (i == 48) begin
        checks++;
        if (pendingCount0 !== 3'd0 || longPulse0 !== 1'b1) begin
          failures++;
          $display("FAIL queued_start48 pend=%0d lp=%b exp=0/1",
                   pendingCount0, longPulse0);
        end
      end
      if (i == 72) begin
        checks++;
        if (busy0 !== 1'b0) begin
          failures++;
          $display("FAIL queued_busy72 got=%b exp=0", busy0);
        end
      end
    end
    checks++;
    if (starts != 3) begin
      failures++;
      $display("FAIL queued_pulses got=%0d exp=3", starts);
    end
  endtask

  task automatic test_overflow();
    int starts;
    logic prev;
    starts = 0;
    prev = longPulse0;
    for (int i = 0; i < 200; i++) begin
      tick(i < 9, 1'b0, 1'b0, 1'b0, 1'b0);
      if (longPulse0 === 1'b1 && prev !== 1'b1) starts++;
      prev = longPulse0;
      if (i == 7) begin
        checks++;
        if (pendingCount0 !== 3'd7 || overflow0 !== 1'b0) begin
          failures++;
          $display("FAIL ovf_sat pend=%0d ovf=%b exp=7/0",
                   pendingCount0, overflow0);
        end
      end
      if (i == 8) begin
        checks++;
        if (pendingCount0 !== 3'd7 || overflow0 !== 1'b1) begin
          failures++;
          $display("FAIL ovf_drop pend=%0d ovf=%b exp=7/1",
                   pendingCount0, overflow0);
        end
      end
    end
    checks++;
    if (starts != 8) begin
      failures++;
      $display("FAIL ovf_pulses got=%0d exp=8", starts);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (overflow0 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=0", overflow0);
    end
  endtask

  task automatic test_collision();
    for (int i = 0; i < 200; i++) begin
      tick(i < 9, i == 8, 1'b0, 1'b0, 1'b0);
      if (i == 8) begin
        checks++;
        if (overflow0 !== 1'b1) begin
          failures++;
          $display("FAIL collide_ovf got=%b exp=1", overflow0);
        end
      end
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_end_gap();
    for (int i = 0; i < 80; i++) begin
      tick(i == 0 || i == 5 || i == 24,
           1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 24) begin
        checks++;
        if (pendingCount0 !== 3'd1 || longPulse0 !== 1'b1) begin
          failures++;
          $display("FAIL endgap pend=%0d lp=%b exp=1/1",
                   pendingCount0, longPulse0);
        end
      end
    end
  endtask

  task automatic test_midreset();
    int highs;
    for (int i = 0; i < 11; i++) begin
      tick(i < 4, 1'b0, i == 10, 1'b0, 1'b0);
      if (i == 3) begin
        checks++;
        if (pendingCount0 !== 3'd3) begin
          failures++;
          $display("FAIL midrst_pend got=%0d exp=3",
                   pendingCount0);
        end
      end
    end
    checks++;
    if ({longPulse0, busy0, pendingCount0} !== 5'b0) begin
      failures++;
      $display("FAIL midrst_clear lp=%b busy=%b pend=%0d exp=0",
               longPulse0, busy0, pendingCount0);
    end
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (longPulse0 !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin
      failures++;
      $display("FAIL midrst_quiet got=%0d exp=0", highs);
    end
  endtask

  task automatic test_gap0();
    logic [2:0] seen;
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 1'b0, i < 2, 1'b0);
      if (i < 3) seen[i] = longPulse1;
    end
    checks++;
    if (seen !== 3'b011) begin
      failures++;
      $display("FAIL gap0_pulses got=%b exp=011", seen);
    end
    checks++;
    if (busy1 !== 1'b0) begin
      failures++;
      $display("FAIL gap0_idle got=%b exp=0", busy1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_queued();
    test_overflow();
    test_collision();
    test_end_gap();
    test_midreset();
    test_gap0();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
